// File: rtl/rv32i_mc_controller.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing the shared ALU datapath,
// with memory-ready stalls in fetch/load/store and flag-resolved branches.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <- PC+4 when memory is ready
// DECODE   | ALUOut <- OldPC+Imm, dispatch on opcode
// MEMADR   | ALUOut <- rs1+Imm (load/store address)
// MEMREAD  | wait for load data
// MEMWB    | rd <- read data
// MEMWRITE | hold store until memory is ready
// EXECR    | ALU on rs1, rs2
// EXECI    | ALU on rs1, Imm
// ALUWB    | rd <- ALUOut
// BRANCH   | compare rs1-rs2, PC <- target when taken
// JAL      | PC <- target, ALUOut <- OldPC+4
// JALR1    | ALUOut <- rs1+Imm
// JALR2    | PC <- ALUOut, ALUOut <- OldPC+4
// LUI      | ALUOut <- Imm
// AUIPC    | ALUOut <- OldPC+Imm
module rv32i_mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  nzcv,
    input  logic        mem_ready,
    output logic [4:0]  ALUControl,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        retire,
    output logic        illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b10000;

    state_t state, state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       legal_op;
    logic       take;
    logic [2:0] imm_dec;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign f7b5        = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [4:0] alu_dec(input logic [2:0] f3, input logic alt, input logic is_r);
        logic [4:0] code;
        case (f3)
            3'b000:  code = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  code = 5'b00110;
            3'b010:  code = 5'b00101;
            3'b011:  code = 5'b01001;
            3'b100:  code = 5'b00100;
            3'b101:  code = alt ? 5'b01000 : 5'b00111;
            3'b110:  code = 5'b00011;
            default: code = 5'b00010;
        endcase
        return code;
    endfunction

    always_comb begin
        legal_op = 1'b1;
        imm_dec  = 3'b000;
        case (opcode)
            OP_LOAD, OP_R, OP_I, OP_JALR: imm_dec = 3'b000;
            OP_STORE:                     imm_dec = 3'b001;
            OP_BR:                        imm_dec = 3'b010;
            OP_JAL:                       imm_dec = 3'b011;
            OP_LUI, OP_AUIPC:             imm_dec = 3'b100;
            default:                      legal_op = 1'b0;
        endcase
    end

    // nzcv = {N,Z,C,V} from rs1-rs2; C set means no borrow
    always_comb begin
        case (funct3)
            3'b000:  take = nzcv[2];
            3'b001:  take = ~nzcv[2];
            3'b100:  take = nzcv[3] ^ nzcv[0];
            3'b101:  take = ~(nzcv[3] ^ nzcv[0]);
            3'b110:  take = ~nzcv[1];
            3'b111:  take = nzcv[1];
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECR;
                    OP_I:              state_next = EXECI;
                    OP_BR:             state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR1;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = AUIPC;
                    default:           state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = opcode[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, JALR2, LUI, AUIPC: state_next = ALUWB;
            JALR1:    state_next = JALR2;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ImmSrc     = imm_dec;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~legal_op;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b00;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec(funct3, f7b5, 1'b1);
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, f7b5, 1'b0);
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                ResultSrc  = 2'b00;
                PCWrite    = take;
                retire     = 1'b1;
                illegal    = (funct3[2:1] == 2'b01);
            end
            JAL, JALR2: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
            end
            JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
        // reset forces FETCH, but fetch's enables must not follow mem_ready then
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Bench for rv32i_mc_controller: per-instruction expected cycle lists built
// from the instruction's class, compared every cycle, plus literal pins.
module tb_rv32i_mc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [3:0]  nzcv = 4'h0;
    logic        mem_ready = 1'b1;
    logic [4:0]  ALUControl;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal;

    rv32i_mc_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .nzcv(nzcv), .mem_ready(mem_ready),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mr;
        logic [3:0] fl;
        logic       c_alu; logic [4:0] alu;
        logic       c_sa;  logic [1:0] sa;
        logic       c_sb;  logic [1:0] sb;
        logic       c_rs;  logic [1:0] rs;
        logic       c_imm; logic [2:0] imm;
        logic       c_adr; logic       adr;
        logic       irw, pcw, rw, mw, ret, ill;
    } cyc_t;

    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] SUB = 5'b10000;

    cyc_t  q[$];
    cyc_t  cur;
    logic  chk_on = 1'b0;
    logic  done = 1'b0;
    logic  fin = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;

    string       ln[$];
    logic [31:0] la[$];
    logic [31:0] le[$];

    logic [4:0] alu_seen [32];
    logic       pcw_seen [32];
    logic [1:0] rs_seen  [32];
    int rw_cnt, mw_cnt, ret_at, ill_at, wr_after1;
    logic [5:0] ab_en;
    logic [5:0] ab_src;

    function automatic void lit(input string n, input logic [31:0] a, input logic [31:0] e);
        ln.push_back(n);
        la.push_back(a);
        le.push_back(e);
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c.mr = 1'($urandom_range(0, 1));
        c.fl = 4'($urandom_range(0, 15));
        c.c_alu = 0; c.alu = 0; c.c_sa = 0; c.sa = 0; c.c_sb = 0; c.sb = 0;
        c.c_rs = 0; c.rs = 0; c.c_imm = 0; c.imm = 0; c.c_adr = 0; c.adr = 0;
        c.irw = 0; c.pcw = 0; c.rw = 0; c.mw = 0; c.ret = 0; c.ill = 0;
        return c;
    endfunction

    function automatic cyc_t ops(input cyc_t ci, input logic [1:0] a, input logic [1:0] b, input logic [4:0] f);
        cyc_t c = ci;
        c.c_sa = 1; c.sa = a; c.c_sb = 1; c.sb = b; c.c_alu = 1; c.alu = f;
        return c;
    endfunction

    function automatic cyc_t with_imm(input cyc_t ci, input logic [2:0] i);
        cyc_t c = ci;
        c.c_imm = 1; c.imm = i;
        return c;
    endfunction

    // ALU operation named by funct3 (and the alternate bit) in the ISA
    function automatic logic [4:0] exp_alu(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'd0: return (is_r && alt) ? SUB : ADD;
            3'd1: return 5'b00110;
            3'd2: return 5'b00101;
            3'd3: return 5'b01001;
            3'd4: return 5'b00100;
            3'd5: return alt ? 5'b01000 : 5'b00111;
            3'd6: return 5'b00011;
            default: return 5'b00010;
        endcase
    endfunction

    // branch condition from flags of rs1-rs2: eq, ne, lt, ge, ltu, geu
    function automatic logic exp_take(input logic [3:0] fl, input logic [2:0] f3);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return !c;
            3'd7: return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push_aluwb();
        cyc_t c = blank();
        c.c_rs = 1; c.rs = 2'b00; c.rw = 1; c.ret = 1;
        q.push_back(c);
    endfunction

    task automatic build(input logic [31:0] ins, input int wf, input int wm, input bit frc, input logic [3:0] bfl);
        cyc_t c;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic       alt = ins[30];
        bit         legal;
        logic [2:0] dimm;
        q.delete();
        for (int i = 0; i < wf; i++) begin
            c = ops(blank(), 2'b00, 2'b10, ADD);
            c.mr = 0; c.c_rs = 1; c.rs = 2'b10; c.c_adr = 1; c.adr = 0;
            q.push_back(c);
        end
        c = ops(blank(), 2'b00, 2'b10, ADD);
        c.mr = 1; c.c_rs = 1; c.rs = 2'b10; c.c_adr = 1; c.adr = 0; c.irw = 1; c.pcw = 1;
        q.push_back(c);
        legal = 1;
        case (op)
            7'h03, 7'h13, 7'h33, 7'h67: dimm = 3'b000;
            7'h23: dimm = 3'b001;
            7'h63: dimm = 3'b010;
            7'h6F: dimm = 3'b011;
            7'h37, 7'h17: dimm = 3'b100;
            default: begin legal = 0; dimm = 3'b000; end
        endcase
        c = ops(blank(), 2'b01, 2'b01, ADD);
        if (legal && op != 7'h33) c = with_imm(c, dimm);
        c.ill = !legal;
        q.push_back(c);
        if (!legal) return;
        case (op)
            7'h03, 7'h23: begin
                q.push_back(with_imm(ops(blank(), 2'b10, 2'b01, ADD), dimm));
                for (int i = 0; i <= wm; i++) begin
                    c = blank();
                    c.mr = (i == wm);
                    c.c_adr = 1; c.adr = 1;
                    if (op == 7'h23) begin
                        c.mw = 1; c.ret = (i == wm);
                    end else begin
                        c.c_rs = 1; c.rs = 2'b00;
                    end
                    q.push_back(c);
                end
                if (op == 7'h03) begin
                    c = blank();
                    c.c_rs = 1; c.rs = 2'b01; c.rw = 1; c.ret = 1;
                    q.push_back(c);
                end
            end
            7'h33: begin
                q.push_back(ops(blank(), 2'b10, 2'b00, exp_alu(f3, alt, 1)));
                push_aluwb();
            end
            7'h13: begin
                q.push_back(with_imm(ops(blank(), 2'b10, 2'b01, exp_alu(f3, alt, 0)), 3'b000));
                push_aluwb();
            end
            7'h63: begin
                c = ops(blank(), 2'b10, 2'b00, SUB);
                if (frc) c.fl = bfl;
                c.c_rs = 1; c.rs = 2'b00; c.pcw = exp_take(c.fl, f3); c.ret = 1;
                c.ill = (f3 == 3'd2 || f3 == 3'd3);
                q.push_back(c);
            end
            7'h6F, 7'h67: begin
                if (op == 7'h67) q.push_back(with_imm(ops(blank(), 2'b10, 2'b01, ADD), 3'b000));
                c = ops(blank(), 2'b01, 2'b10, ADD);
                c.c_rs = 1; c.rs = 2'b00; c.pcw = 1;
                q.push_back(c);
                push_aluwb();
            end
            default: begin
                q.push_back(with_imm(ops(blank(), (op == 7'h37) ? 2'b11 : 2'b01, 2'b01, ADD), 3'b100));
                push_aluwb();
            end
        endcase
    endtask

    // entered and left at posedge+1
    task automatic run(input logic [31:0] ins, input int wf, input int wm, input bit frc,
                       input logic [3:0] bfl, input int abort_at);
        build(ins, wf, wm, frc, bfl);
        rw_cnt = 0; mw_cnt = 0; ret_at = 0; ill_at = 0; wr_after1 = 0;
        for (int k = 0; k < 32; k++) begin
            alu_seen[k] = '0; pcw_seen[k] = 0; rs_seen[k] = '0;
        end
        for (int k = 0; k < q.size(); k++) begin
            instr = ins; mem_ready = q[k].mr; nzcv = q[k].fl; cur = q[k]; chk_on = 1;
            @(negedge clk);
            if (k < 32) begin
                alu_seen[k] = ALUControl; pcw_seen[k] = PCWrite; rs_seen[k] = ResultSrc;
            end
            if (RegWrite) rw_cnt++;
            if (MemWrite) mw_cnt++;
            if (retire) ret_at = k + 1;
            if (illegal) ill_at = k + 1;
            if (k >= 1 && (IRWrite || PCWrite || RegWrite || MemWrite)) wr_after1++;
            if (k + 1 == abort_at) begin
                chk_on = 0;
                mem_ready = 1;
                #1 reset = 1;
                #1 ab_en = {IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal};
                ab_src = {ALUSrcA, ALUSrcB, ResultSrc};
                @(posedge clk); #1;
                @(negedge clk);
                if (RegWrite || IRWrite) ab_en = ab_en | 6'b100000;
                @(posedge clk); #1;
                reset = 0;
                return;
            end
            @(posedge clk); #1;
        end
        chk_on = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t instr=%h)", nm, act, exp, $time, instr);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (cur.c_alu) chk("ALUControl", 32'(ALUControl), 32'(cur.alu));
            if (cur.c_sa)  chk("ALUSrcA", 32'(ALUSrcA), 32'(cur.sa));
            if (cur.c_sb)  chk("ALUSrcB", 32'(ALUSrcB), 32'(cur.sb));
            if (cur.c_rs)  chk("ResultSrc", 32'(ResultSrc), 32'(cur.rs));
            if (cur.c_imm) chk("ImmSrc", 32'(ImmSrc), 32'(cur.imm));
            if (cur.c_adr) chk("AdrSrc", 32'(AdrSrc), 32'(cur.adr));
            chk("IRWrite", 32'(IRWrite), 32'(cur.irw));
            chk("PCWrite", 32'(PCWrite), 32'(cur.pcw));
            chk("RegWrite", 32'(RegWrite), 32'(cur.rw));
            chk("MemWrite", 32'(MemWrite), 32'(cur.mw));
            chk("retire", 32'(retire), 32'(cur.ret));
            chk("illegal", 32'(illegal), 32'(cur.ill));
        end
        if (done && !fin) begin
            fin = 1;
            for (int i = 0; i < ln.size(); i++) chk(ln[i], la[i], le[i]);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    logic [6:0] legal_ops [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [6:0] bad_ops   [4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};

    initial begin
        logic [31:0] ins;
        int sel;
        reset = 1; mem_ready = 1;
        @(negedge clk);
        lit("reset_enables", 32'({IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal}), 32'd0);
        lit("reset_fetch_muxes", 32'({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}), 32'b00_10_10_0);
        @(posedge clk); #1;
        reset = 0;

        run(32'h002081B3, 0, 0, 0, 4'h0, 0);
        lit("add_alu", 32'(alu_seen[2]), 32'd0);
        lit("add_cycles", 32'(ret_at), 32'd4);
        lit("add_regwrite_count", 32'(rw_cnt), 32'd1);
        run(32'h402081B3, 1, 0, 0, 4'h0, 0);
        lit("sub_alu", 32'(alu_seen[3]), 32'b10000);
        run(32'h4010D093, 0, 0, 0, 4'h0, 0);
        lit("srai_alu", 32'(alu_seen[2]), 32'b01000);
        run(32'h00208063, 0, 0, 1, 4'b0100, 0);
        lit("beq_z_taken", 32'(pcw_seen[2]), 32'd1);
        lit("branch_cycles", 32'(ret_at), 32'd3);
        run(32'h00208063, 0, 0, 1, 4'b0000, 0);
        lit("beq_nz_not_taken", 32'(pcw_seen[2]), 32'd0);
        run(32'h0020C063, 0, 0, 1, 4'b1000, 0);
        lit("blt_taken", 32'(pcw_seen[2]), 32'd1);
        run(32'h0020F063, 0, 0, 1, 4'b0010, 0);
        lit("bgeu_taken", 32'(pcw_seen[2]), 32'd1);
        run(32'h0000A183, 0, 2, 0, 4'h0, 0);
        lit("lw_model_len", 32'(q.size()), 32'd7);
        lit("lw_cycles", 32'(ret_at), 32'd7);
        lit("lw_regwrite_count", 32'(rw_cnt), 32'd1);
        lit("lw_wb_resultsrc", 32'(rs_seen[6]), 32'd1);
        run(32'h0030A023, 0, 3, 0, 4'h0, 0);
        lit("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
        lit("sw_retire_cycle", 32'(ret_at), 32'd7);
        run(32'h0000007F, 0, 0, 0, 4'h0, 0);
        lit("illegal_cycle", 32'(ill_at), 32'd2);
        lit("illegal_no_writes", 32'(wr_after1), 32'd0);
        lit("illegal_no_retire", 32'(ret_at), 32'd0);
        run(32'h002081B3, 0, 0, 0, 4'h0, 3);
        lit("abort_enables", 32'(ab_en), 32'd0);
        lit("abort_fetch_muxes", 32'(ab_src), 32'b00_10_10);
        lit("abort_regwrite_count", 32'(rw_cnt), 32'd0);
        run(32'h002081B3, 0, 0, 0, 4'h0, 0);
        lit("after_abort_cycles", 32'(ret_at), 32'd4);

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 10);
            ins[6:0] = (sel < 9) ? legal_ops[sel] : bad_ops[$urandom_range(0, 3)];
            run(ins, $urandom_range(0, 3), $urandom_range(0, 3), 0, 4'h0, 0);
        end

        done = 1;
        repeat (10) @(posedge clk);
        $display("FAIL summary_timeout: compare process did not finish");
        $fatal(1, "bench did not terminate");
    end
endmodule
